// File: rtl/mp2_bitstream_shifter.sv
// MP2 bitstream shifter: pulls 16-bit words from a FWFT FIFO and presents a
// left-aligned 16-bit window that consumers advance by 1..16 bits per request.
module mp2_bitstream_shifter #(
    parameter int MAX_SHIFT = 16,
    parameter int BUF_BITS  = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        Resync_I,
    input  logic [15:0] Word_Data_I,
    input  logic        Word_Valid_I,
    output logic        Word_Read_O,
    output logic [15:0] Bitstream_Data_O,
    output logic        Bitstream_Byte_Allign_O,
    input  logic [4:0]  Shift_En_I,
    output logic        Shift_Busy_O,
    output logic [15:0] Bits_Consumed_O
);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        READY = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [BUF_BITS-1:0] bit_buf_r;
    logic [5:0]          cnt_r;
    logic [2:0]          bpos_r;
    logic [15:0]         consumed_r;
    logic                busy_r;
    logic                align_r;

    logic [4:0]          n_s;
    logic                accept_s;
    logic                pop_s;
    logic [BUF_BITS-1:0] shifted_buf_s;
    logic [BUF_BITS-1:0] insert_s;
    logic [BUF_BITS-1:0] buf_next_s;
    logic [5:0]          cnt_shift_s;
    logic [5:0]          cnt_next_s;
    logic [2:0]          bpos_next_s;
    logic [15:0]         consumed_next_s;

    // Shift clamp, same-cycle shift-then-insert datapath and next-state decode.
    always_comb begin
        n_s = (Shift_En_I > 5'(MAX_SHIFT)) ? 5'(MAX_SHIFT) : Shift_En_I;
        // busy_r low implies READY, which guarantees cnt >= 16 >= n.
        accept_s = (n_s != 5'd0) && !busy_r && !Resync_I && !reset;

        if (accept_s) begin
            shifted_buf_s   = bit_buf_r << n_s;
            cnt_shift_s     = cnt_r - {1'b0, n_s};
            bpos_next_s     = bpos_r + n_s[2:0];
            consumed_next_s = consumed_r + {11'd0, n_s};
        end else begin
            shifted_buf_s   = bit_buf_r;
            cnt_shift_s     = cnt_r;
            bpos_next_s     = bpos_r;
            consumed_next_s = consumed_r;
        end

        pop_s = Word_Valid_I && (cnt_shift_s <= 6'd16) && (state_r != FLUSH)
                && !Resync_I && !reset;
        // Placing the word just below the cnt_shift_s surviving bits.
        insert_s = {Word_Data_I, 16'h0000} >> cnt_shift_s;

        if (pop_s) begin
            buf_next_s = shifted_buf_s | insert_s;
            cnt_next_s = cnt_shift_s + 6'd16;
        end else begin
            buf_next_s = shifted_buf_s;
            cnt_next_s = cnt_shift_s;
        end

        case (state_r)
            FILL:    state_next_s = (cnt_r >= 6'd16) ? READY : FILL;
            READY:   state_next_s = (cnt_next_s < 6'd16) ? FILL : READY;
            FLUSH:   state_next_s = FILL;
            default: state_next_s = FILL;
        endcase
    end

    // State, buffer and registered status outputs; resync overrides any update.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= FILL;
            bit_buf_r  <= '0;
            cnt_r      <= 6'd0;
            bpos_r     <= 3'd0;
            consumed_r <= 16'd0;
            busy_r     <= 1'b1;
            align_r    <= 1'b1;
        end else if (Resync_I) begin
            state_r    <= FLUSH;
            bit_buf_r  <= '0;
            cnt_r      <= 6'd0;
            bpos_r     <= 3'd0;
            consumed_r <= 16'd0;
            busy_r     <= 1'b1;
            align_r    <= 1'b1;
        end else begin
            state_r    <= state_next_s;
            bit_buf_r  <= buf_next_s;
            cnt_r      <= cnt_next_s;
            bpos_r     <= bpos_next_s;
            consumed_r <= consumed_next_s;
            busy_r     <= (state_next_s != READY);
            align_r    <= (bpos_next_s == 3'd0);
        end
    end

    // The pop strobe must act on the FWFT head in the same cycle, so it stays combinational.
    assign Word_Read_O             = pop_s;
    assign Bitstream_Data_O        = bit_buf_r[BUF_BITS-1 -: 16];
    assign Bitstream_Byte_Allign_O = align_r;
    assign Shift_Busy_O            = busy_r;
    assign Bits_Consumed_O         = consumed_r;

endmodule
